// File: rtl/synch.sv
// synch: Schmidl-Cox coarse time synchronizer. Tracks the delayed autocorrelation P
// and window energy R of the incoming stream, locks on the periodic preamble plateau,
// then forwards samples on a Wishbone-style master port until the burst ends.
module synch #(
  parameter int D          = 512,
  parameter int L          = 512,
  parameter int PLAT_LEN   = 64,
  parameter int MIN_ENERGY = 4096
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] DAT_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  output logic        ACK_O,
  output logic [31:0] DAT_O,
  output logic        WE_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic        ACK_I
);

  localparam int DW = $clog2(D);
  localparam int LW = $clog2(L);
  localparam int FW = $clog2(D + L + 1);
  localparam int PW = $clog2(PLAT_LEN + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      plat_q, plat_d;
  logic [FW-1:0]      fill_q;
  logic [DW-1:0]      ptr_d_q;
  logic [LW-1:0]      ptr_l_q;
  logic signed [24:0] p_re_q, p_im_q;
  logic [25:0]        r_q;
  logic               cm_val_q;
  logic               stb_q;
  logic [31:0]        dat_q;

  // Probe names for the metric; the hit logic below reads these directly.
  logic signed [24:0] P_Re, P_Im;
  logic [25:0]        R_Metric;
  logic               CM_val;
  assign P_Re     = p_re_q;
  assign P_Im     = p_im_q;
  assign R_Metric = r_q;
  assign CM_val   = cm_val_q;

  // Delay lines: reduced samples (lag D), correlation terms and energies (lag L).
  logic [15:0] r_mem [D];
  logic [33:0] c_mem [L];
  logic [15:0] e_mem [L];

  logic accept;
  assign accept = RST_I & CYC_I & STB_I & (~stb_q | ACK_I);
  assign ACK_O  = accept;

  // Reduce to 8-bit Im/Re; delayed entries older than the burst fill read as zero.
  logic [15:0]       r_new, r_old;
  logic signed [7:0] x_re, x_im, y_re, y_im;
  assign r_new = {DAT_I[31:24], DAT_I[15:8]};
  assign r_old = (fill_q >= FW'(D)) ? r_mem[ptr_d_q] : '0;
  assign x_re  = r_new[7:0];
  assign x_im  = r_new[15:8];
  assign y_re  = r_old[7:0];
  assign y_im  = r_old[15:8];

  // c(n) = r(n) * conj(r(n-D)); e(n) = |r(n)|^2.
  logic signed [16:0] c_re, c_im, c_old_re, c_old_im;
  logic [15:0]        e_new, e_old;
  logic [33:0]        c_old;
  assign c_re  = 17'(x_re) * 17'(y_re) + 17'(x_im) * 17'(y_im);
  assign c_im  = 17'(x_im) * 17'(y_re) - 17'(x_re) * 17'(y_im);
  assign e_new = 16'(17'(x_re) * 17'(x_re) + 17'(x_im) * 17'(x_im));
  assign c_old = (fill_q >= FW'(L)) ? c_mem[ptr_l_q] : '0;
  assign e_old = (fill_q >= FW'(L)) ? e_mem[ptr_l_q] : '0;
  assign c_old_re = c_old[33:17];
  assign c_old_im = c_old[16:0];

  // Delay-line writes, one entry per accepted sample.
  // NOTE: the delay-line RAMs have no reset; stale words are masked by fill_q instead.
  always_ff @(posedge CLK_I) begin
    if (accept) begin
      r_mem[ptr_d_q] <= r_new;
      c_mem[ptr_l_q] <= {c_re, c_im};
      e_mem[ptr_l_q] <= e_new;
    end
  end

  // Running sums, fill counter and metric-valid strobe; cleared on reset or burst end.
  // NOTE: registered state is assigned only with <= so every flop sees pre-edge values.
  always_ff @(posedge CLK_I) begin
    if (!RST_I || !CYC_I) begin
      fill_q   <= '0;
      ptr_d_q  <= '0;
      ptr_l_q  <= '0;
      p_re_q   <= '0;
      p_im_q   <= '0;
      r_q      <= '0;
      cm_val_q <= 1'b0;
    end else begin
      cm_val_q <= accept && (fill_q >= FW'(D + L - 1));
      if (accept) begin
        p_re_q  <= p_re_q + 25'(c_re) - 25'(c_old_re);
        p_im_q  <= p_im_q + 25'(c_im) - 25'(c_old_im);
        r_q     <= r_q + 26'(e_new) - 26'(e_old);
        ptr_d_q <= (ptr_d_q == DW'(D - 1)) ? '0 : ptr_d_q + DW'(1);
        ptr_l_q <= (ptr_l_q == LW'(L - 1)) ? '0 : ptr_l_q + LW'(1);
        if (fill_q != FW'(D + L)) fill_q <= fill_q + FW'(1);
      end
    end
  end

  // Plateau test: |P| approximated as max + min/2, compared against 0.75 R.
  logic [24:0] abs_re, abs_im, mx, mn;
  logic [26:0] mag, thr;
  logic        hit;
  assign abs_re = P_Re[24] ? 25'(-P_Re) : 25'(P_Re);
  assign abs_im = P_Im[24] ? 25'(-P_Im) : 25'(P_Im);
  assign mx     = (abs_re >= abs_im) ? abs_re : abs_im;
  assign mn     = (abs_re >= abs_im) ? abs_im : abs_re;
  assign mag    = 27'(mx) + 27'(mn >> 1);
  assign thr    = 27'(R_Metric) - 27'(R_Metric >> 2);
  assign hit    = CM_val && (R_Metric >= 26'(MIN_ENERGY)) && (mag >= thr);

  // FSM state register.
  always_ff @(posedge CLK_I) begin
    if (!RST_I || !CYC_I) begin
      state_q <= SEARCH;
      plat_q  <= '0;
    end else begin
      state_q <= state_d;
      plat_q  <= plat_d;
    end
  end

  // FSM next state: count consecutive hits while searching; lock is sticky.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    plat_d  = plat_q;
    if (state_q == SEARCH && CM_val) begin
      if (hit) begin
        if (plat_q == PW'(PLAT_LEN - 1)) begin
          state_d = LOCKED;
          plat_d  = '0;
        end else begin
          plat_d = plat_q + PW'(1);
        end
      end else begin
        plat_d = '0;
      end
    end
  end

  // Output stage: one-entry register, held under backpressure, dropped at burst end.
  always_ff @(posedge CLK_I) begin
    if (!RST_I || !CYC_I) begin
      stb_q <= 1'b0;
      dat_q <= '0;
    end else if (accept && state_q == LOCKED) begin
      stb_q <= 1'b1;
      dat_q <= DAT_I;
    end else if (ACK_I) begin
      stb_q <= 1'b0;
    end
  end

  assign CYC_O = (state_q == LOCKED);
  assign STB_O = stb_q;
  assign WE_O  = stb_q;
  assign DAT_O = dat_q;

endmodule

// File: tb/tb_synch.sv
// tb_synch: directed bench for synch with a window-sum reference model checked every cycle.
module tb_synch;

  localparam int D    = 512;
  localparam int L    = 512;
  localparam int PLAT = 64;
  localparam int MINE = 4096;
  localparam logic [31:0] C = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] dat_in = C;
  logic        cyc_in = 1'b1;
  logic        stb_in = 1'b1;
  logic        ack_in = 1'b1;
  logic        ack_out, we_out, stb_out, cyc_out;
  logic [31:0] dat_out;

  always #5 clk = ~clk;

  synch #(.D(D), .L(L), .PLAT_LEN(PLAT), .MIN_ENERGY(MINE)) dut (
    .CLK_I(clk), .RST_I(rst), .DAT_I(dat_in), .CYC_I(cyc_in), .STB_I(stb_in),
    .ACK_O(ack_out), .DAT_O(dat_out), .WE_O(we_out), .STB_O(stb_out),
    .CYC_O(cyc_out), .ACK_I(ack_in)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name,
               $signed(act), act, $signed(exp), exp);
    end
  endtask

  // ---------------- reference model ----------------
  int   q_re[$];
  int   q_im[$];
  bit   started  = 0;
  bit   m_stb    = 0;
  bit   m_locked = 0;
  bit   m_cmval  = 0;
  logic [31:0] m_dat = '0;
  int   m_pre = 0, m_pim = 0, m_r = 0, m_plat = 0;
  int   first_pre = 0, first_pim = 0, first_r = 0;

  // P and R straight from their definitions over the last L accepted samples.
  function automatic void window(output int pre, output int pim, output int rr);
    int n = q_re.size();
    pre = 0; pim = 0; rr = 0;
    for (int k = n - L; k < n; k++) begin
      int a = q_re[k];
      int b = q_im[k];
      int c = 0;
      int d = 0;
      if (k >= D) begin
        c = q_re[k - D];
        d = q_im[k - D];
      end
      pre += a * c + b * d;
      pim += b * c - a * d;
      rr  += a * a + b * b;
    end
  endfunction

  function automatic bit model_hit(input int pre, input int pim, input int rr);
    int ar = (pre < 0) ? -pre : pre;
    int ai = (pim < 0) ? -pim : pim;
    int mx = (ar > ai) ? ar : ai;
    int mn = (ar > ai) ? ai : ar;
    return (rr >= MINE) && ((mx + mn / 2) >= (rr - rr / 4));
  endfunction

  // Compare DUT against the model, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    if (started) begin
      bit exp_ack;
      bit nxt_locked;
      int v;
      check("cyc_o", cyc_out, m_locked);
      check("stb_o", stb_out, m_stb);
      check("we_o", we_out, m_stb);
      if (m_stb) check("dat_o", dat_out, m_dat);
      check("cm_val", dut.CM_val, m_cmval);
      if (m_cmval) begin
        check("p_re", dut.P_Re, m_pre);
        check("p_im", dut.P_Im, m_pim);
        check("r_metric", dut.R_Metric, m_r);
      end
      exp_ack = rst && cyc_in && stb_in && (!m_stb || ack_in);
      check("ack_o", ack_out, exp_ack);

      if (!rst || !cyc_in) begin
        m_stb = 0; m_locked = 0; m_cmval = 0; m_plat = 0;
        if (!rst) m_dat = '0;
        q_re.delete();
        q_im.delete();
      end else begin
        nxt_locked = m_locked;
        if (!m_locked && m_cmval) begin
          if (model_hit(m_pre, m_pim, m_r)) begin
            m_plat++;
            if (m_plat == PLAT) begin
              nxt_locked = 1;
              m_plat = 0;
            end
          end else begin
            m_plat = 0;
          end
        end
        if (exp_ack && m_locked) begin
          m_stb = 1;
          m_dat = dat_in;
        end else if (ack_in) begin
          m_stb = 0;
        end
        m_cmval = 0;
        if (exp_ack) begin
          v = $signed(dat_in[15:8]);
          q_re.push_back(v);
          v = $signed(dat_in[31:24]);
          q_im.push_back(v);
          if (q_re.size() >= D + L) begin
            window(m_pre, m_pim, m_r);
            m_cmval = 1;
            if (q_re.size() == D + L) begin
              first_pre = m_pre; first_pim = m_pim; first_r = m_r;
            end
          end
        end
        m_locked = nxt_locked;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic c, input logic s, input logic a,
                       input logic [31:0] d);
    @(posedge clk);
    #1;
    rst = r; cyc_in = c; stb_in = s; ack_in = a; dat_in = d;
  endtask

  // Feed constant C until CYC_O rises; returns the cycle count and first-metric snapshot.
  task automatic run_to_lock(output int n_lock, output int n_cm, output int p_re,
                             output int p_im, output int r_m);
    int n = 0;
    n_lock = -1; n_cm = -1; p_re = 0; p_im = 0; r_m = 0;
    while (n_lock < 0 && n < 2200) begin
      drive(1, 1, 1, 1, C);
      n++;
      @(negedge clk);
      if (dut.CM_val && n_cm < 0) begin
        n_cm = n; p_re = dut.P_Re; p_im = dut.P_Im; r_m = dut.R_Metric;
      end
      if (cyc_out) n_lock = n;
    end
  endtask

  int  pat [D];
  int  n_lock, n_cm, p_re, p_im, r_m;
  bit  saw;

  initial begin
    // Reset held with an active burst request.
    @(posedge clk);
    #1;
    started = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack_o", ack_out, 0);
    check("rst_cyc_o", cyc_out, 0);
    check("rst_stb_o", stb_out, 0);
    check("rst_dat_o", dat_out, 0);

    // Constant tone: plateau from sample D+L, lock after PLAT_LEN hits.
    run_to_lock(n_lock, n_cm, p_re, p_im, r_m);
    check("const_first_cm_cycle", n_cm, D + L + 1);
    check("const_p_re", p_re, 2097152);
    check("const_p_im", p_im, 0);
    check("const_r", r_m, 2097152);
    check("model_first_p_re", first_pre, 2097152);
    check("model_first_p_im", first_pim, 0);
    check("model_first_r", first_r, 2097152);
    check("const_lock_cycle", n_lock, D + L + PLAT + 1);
    drive(1, 1, 1, 1, C | 32'd1);
    @(negedge clk);
    check("first_out_stb", stb_out, 1);
    check("first_out_dat", dat_out, C);

    // Backpressure: tagged samples in the low bytes, 5-cycle stall, resume.
    for (int i = 2; i <= 10; i++) drive(1, 1, 1, 1, C | 32'(i));
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 1, 0, C | 32'hEE);
      @(negedge clk);
      check("bp_ack_o", ack_out, 0);
      check("bp_stb_o", stb_out, 1);
      check("bp_dat_o", dat_out, C | 32'd10);
    end
    drive(1, 1, 1, 1, C | 32'd11);
    @(negedge clk);
    check("resume_ack_o", ack_out, 1);
    check("resume_dat_o", dat_out, C | 32'd10);
    drive(1, 1, 1, 1, C | 32'd12);
    @(negedge clk);
    check("resume_next_dat_o", dat_out, C | 32'd11);

    // Input gap: STB_O falls once the last sample is taken.
    drive(1, 1, 0, 1, C);
    drive(1, 1, 0, 1, C);
    @(negedge clk);
    check("gap_stb_o", stb_out, 0);

    // Burst end with a pending stalled sample, then a second burst re-locks.
    drive(1, 1, 1, 1, C | 32'd5);
    drive(1, 0, 1, 0, C);
    drive(1, 1, 1, 1, C);
    @(negedge clk);
    check("eob_cyc_o", cyc_out, 0);
    check("eob_stb_o", stb_out, 0);
    run_to_lock(n_lock, n_cm, p_re, p_im, r_m);
    check("relock_cycle", n_lock + 1, D + L + PLAT + 1);
    check("relock_p_re", p_re, 2097152);
    drive(1, 0, 0, 1, 32'd0);
    drive(1, 0, 0, 1, 32'd0);

    // All-zero burst: no energy, no lock.
    saw = 0;
    for (int i = 0; i < 6 * 2560; i++) begin
      drive(1, 1, 1, 1, 32'd0);
      @(negedge clk);
      if (cyc_out) saw = 1;
    end
    check("zero_no_lock", saw, 0);
    check("zero_r", dut.R_Metric, 0);
    drive(1, 0, 0, 1, 32'd0);

    // Noise, then a D-periodic preamble in the same burst.
    saw = 0;
    for (int i = 0; i < 4096; i++) begin
      drive(1, 1, 1, 1, $urandom);
      @(negedge clk);
      if (cyc_out) saw = 1;
    end
    check("noise_no_lock", saw, 0);
    for (int i = 0; i < D; i++) pat[i] = int'($urandom);
    for (int i = 0; i < 2048; i++) drive(1, 1, 1, 1, 32'(pat[i % D]));
    @(negedge clk);
    check("preamble_lock", cyc_out, 1);

    // Reset in the middle of a locked burst.
    drive(0, 1, 1, 1, C);
    @(negedge clk);
    check("midrst_ack_o", ack_out, 0);
    drive(1, 1, 1, 1, C);
    @(negedge clk);
    check("midrst_cyc_o", cyc_out, 0);
    check("midrst_stb_o", stb_out, 0);
    drive(1, 0, 0, 1, 32'd0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
